// File: rtl/shifter_pipe.sv
// Two-stage pipelined barrel shifter with ARM shift semantics.
// Stage 1 normalises the shift amount and flags the immediate special cases
// (shift-by-width, RRX, pass-through); stage 2 performs the shift and
// produces the carry-out. Both stages use a valid/ready handshake, stall on
// backpressure, and can be killed by flush.
module shifter_pipe #(
  parameter int FULLW      = 32,
  parameter int AMTW       = 8,
  parameter int SHIFTCODEW = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [FULLW-1:0]      in_data,
  input  logic [AMTW-1:0]       in_amt,
  input  logic [SHIFTCODEW-1:0] in_code,
  input  logic                  in_imm,
  input  logic                  in_cflag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FULLW-1:0]      out_data,
  output logic                  out_carry
);

  localparam int SHW = $clog2(FULLW);
  // Immediate amounts keep only the bits that index a position in the word.
  localparam logic [AMTW-1:0] IMM_MASK = AMTW'((1 << SHW) - 1);
  localparam logic [31:0]     FULLW_U  = 32'(FULLW);

  typedef enum logic [SHIFTCODEW-1:0] {
    SH_LSL = SHIFTCODEW'(0),
    SH_LSR = SHIFTCODEW'(1),
    SH_ASR = SHIFTCODEW'(2),
    SH_ROR = SHIFTCODEW'(3)
  } shift_code_e;

  // Pipeline control
  logic s1_valid, s2_valid;
  logic s1_adv, s2_adv;

  // Stage-1 payload
  logic [FULLW-1:0] s1_data;
  shift_code_e      s1_code;
  logic             s1_cflag;
  logic [AMTW-1:0]  s1_amt;
  logic             s1_full;   // immediate LSR/ASR #0: shift by the full width
  logic             s1_rrx;    // immediate ROR #0: rotate right through carry
  logic             s1_zero;   // amount 0 with no special meaning: pass through

  // Decode of the incoming request
  logic [AMTW-1:0] d_amt;
  logic            d_full, d_rrx, d_zero;
  shift_code_e     d_code;

  // Stage-2 shift results
  logic [FULLW-1:0] res_data;
  logic             res_carry;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  // Normalise the amount and classify the zero-amount special cases.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned, which would infer a latch.
    d_code = shift_code_e'(in_code);
    d_amt  = in_imm ? (in_amt & IMM_MASK) : in_amt;
    d_full = 1'b0;
    d_rrx  = 1'b0;
    if (in_imm && (d_amt == '0)) begin
      d_full = (d_code == SH_LSR) || (d_code == SH_ASR);
      d_rrx  = (d_code == SH_ROR);
    end
    d_zero = (d_amt == '0) && !d_full && !d_rrx;
  end

  // Stage 1 register: capture the normalised request on an input transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_code  <= SH_LSL;
      s1_cflag <= 1'b0;
      s1_amt   <= '0;
      s1_full  <= 1'b0;
      s1_rrx   <= 1'b0;
      s1_zero  <= 1'b0;
    end else begin
      if (flush) begin
        s1_valid <= 1'b0;
      end else if (s1_adv) begin
        s1_valid <= in_valid;
      end
      if (s1_adv && in_valid && !flush) begin
        s1_data  <= in_data;
        s1_code  <= d_code;
        s1_cflag <= in_cflag;
        s1_amt   <= d_amt;
        s1_full  <= d_full;
        s1_rrx   <= d_rrx;
        s1_zero  <= d_zero;
      end
    end
  end

  // Stage 2 datapath: ARM shift with out-of-range and special-case rules.
  logic [31:0]      n_ext;
  logic             n_eq, n_gt, msb;
  logic [SHW-1:0]   sh;
  logic [FULLW:0]   lsl_w, lsr_w, asr_w;
  logic [FULLW-1:0] rot;

  always_comb begin
    n_ext = 32'(s1_amt);
    n_eq  = s1_full || (n_ext == FULLW_U);
    n_gt  = !s1_full && (n_ext > FULLW_U);
    msb   = s1_data[FULLW-1];
    sh    = s1_amt[SHW-1:0];
    // The extra bit beside the data catches the last bit shifted out.
    lsl_w = {1'b0, s1_data} << sh;
    lsr_w = {s1_data, 1'b0} >> sh;
    asr_w = $signed({s1_data, 1'b0}) >>> sh;
    rot   = (s1_data >> sh) | (s1_data << (FULLW - int'(sh)));

    res_data  = s1_data;
    res_carry = s1_cflag;
    case (s1_code)
      SH_LSL: begin
        if (s1_zero) begin
          res_data  = s1_data;
          res_carry = s1_cflag;
        end else if (n_gt) begin
          res_data  = '0;
          res_carry = 1'b0;
        end else if (n_eq) begin
          res_data  = '0;
          res_carry = s1_data[0];
        end else begin
          res_data  = lsl_w[FULLW-1:0];
          res_carry = lsl_w[FULLW];
        end
      end
      SH_LSR: begin
        if (s1_zero) begin
          res_data  = s1_data;
          res_carry = s1_cflag;
        end else if (n_gt) begin
          res_data  = '0;
          res_carry = 1'b0;
        end else if (n_eq) begin
          res_data  = '0;
          res_carry = msb;
        end else begin
          res_data  = lsr_w[FULLW:1];
          res_carry = lsr_w[0];
        end
      end
      SH_ASR: begin
        if (s1_zero) begin
          res_data  = s1_data;
          res_carry = s1_cflag;
        end else if (n_eq || n_gt) begin
          res_data  = {FULLW{msb}};
          res_carry = msb;
        end else begin
          res_data  = asr_w[FULLW:1];
          res_carry = asr_w[0];
        end
      end
      SH_ROR: begin
        if (s1_rrx) begin
          res_data  = {s1_cflag, s1_data[FULLW-1:1]};
          res_carry = s1_data[0];
        end else if (s1_zero) begin
          res_data  = s1_data;
          res_carry = s1_cflag;
        end else begin
          // A multiple of the width rotates by zero and yields carry = msb.
          res_data  = rot;
          res_carry = rot[FULLW-1];
        end
      end
      default: begin
        res_data  = s1_data;
        res_carry = s1_cflag;
      end
    endcase
  end

  // Stage 2 register: results hold while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      out_data  <= '0;
      out_carry <= 1'b0;
    end else begin
      if (flush) begin
        s2_valid <= 1'b0;
      end else if (s2_adv) begin
        s2_valid <= s1_valid;
      end
      if (s2_adv && s1_valid && !flush) begin
        out_data  <= res_data;
        out_carry <= res_carry;
      end
    end
  end

endmodule
